// File: rtl/urv_seq_divider_if.sv
// urv_seq_divider_if: execute-stage handshake between pipeline control and the sequential divider.
interface urv_seq_divider_if #(parameter int WIDTH = 32);
    logic             x_stall_i;
    logic             x_kill_i;
    logic             x_stall_req_o;
    logic             d_valid_i;
    logic             d_is_divide_i;
    logic [2:0]       d_fun_i;
    logic [WIDTH-1:0] d_rs1_i;
    logic [WIDTH-1:0] d_rs2_i;
    logic [WIDTH-1:0] x_rd_o;
    modport master (
        output x_stall_i, x_kill_i, d_valid_i, d_is_divide_i, d_fun_i, d_rs1_i, d_rs2_i,
        input  x_stall_req_o, x_rd_o
    );
    modport slave (
        input  x_stall_i, x_kill_i, d_valid_i, d_is_divide_i, d_fun_i, d_rs1_i, d_rs2_i,
        output x_stall_req_o, x_rd_o
    );
endinterface

// File: rtl/urv_seq_divider.sv
// urv_seq_divider: multi-cycle restoring DIV/DIVU/REM/REMU for the uRV execute stage.
// Define URV_DIV_EARLY_OUT_EN to skip iteration for div-by-zero, overflow and |rs1| < |rs2|.
module urv_seq_divider #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    urv_seq_divider_if.slave   bus
);
    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(N);
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

    state_t           r_state, w_state_n;
    logic [WIDTH-1:0] r_rs1, r_rs2, r_quo, r_dvs, r_rd;
    logic [WIDTH:0]   r_rem;
    logic [2:0]       r_fun;
    logic [CW-1:0]    r_cnt;
    logic             w_start, w_signed, w_div0, w_ovf, w_early, w_load, w_ge;
    logic [WIDTH-1:0] w_abs1, w_abs2, w_quo, w_rq, w_rr, w_q, w_r, w_res;
    logic [WIDTH:0]   w_rem;
    logic [WIDTH+1:0] w_sh;

    assign w_start  = r_state == IDLE && bus.d_valid_i && bus.d_is_divide_i && !bus.x_kill_i;
    assign w_signed = !r_fun[0] && r_fun[2];
    assign w_abs1   = (w_signed && r_rs1[WIDTH-1]) ? -r_rs1 : r_rs1;
    assign w_abs2   = (w_signed && r_rs2[WIDTH-1]) ? -r_rs2 : r_rs2;
    assign w_div0   = r_rs2 == '0;
    assign w_ovf    = w_signed && r_rs1 == MIN && r_rs2 == '1;
`ifdef URV_DIV_EARLY_OUT_EN
    assign w_early  = w_div0 || w_ovf || (w_abs1 < w_abs2);
`else
    assign w_early  = 1'b0;
`endif

    assign bus.x_stall_req_o = !bus.x_kill_i && (w_start || r_state inside {PREP, ITER, FIX});
    assign bus.x_rd_o        = r_rd;

    // BITS_PER_CYCLE restoring steps chained in one cycle
    always_comb begin
        w_rem = r_rem;
        w_quo = r_quo;
        w_sh  = '0;
        w_ge  = 1'b0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            w_sh  = {w_rem, w_quo[WIDTH-1]};
            w_ge  = w_sh >= {2'b00, r_dvs};
            w_rem = w_ge ? w_sh[WIDTH:0] - {1'b0, r_dvs} : w_sh[WIDTH:0];
            w_quo = {w_quo[WIDTH-2:0], w_ge};
        end
    end

    // early exit in PREP means quotient 0 and remainder |rs1|
    assign w_rq   = r_state == PREP ? '0 : r_quo;
    assign w_rr   = r_state == PREP ? w_abs1 : r_rem[WIDTH-1:0];
    assign w_q    = w_div0 ? '1 : w_ovf ? MIN : (w_signed && (r_rs1[WIDTH-1] ^ r_rs2[WIDTH-1])) ? -w_rq : w_rq;
    assign w_r    = w_div0 ? r_rs1 : w_ovf ? '0 : (w_signed && r_rs1[WIDTH-1]) ? -w_rr : w_rr;
    assign w_res  = r_fun[1] ? w_r : w_q;
    assign w_load = !bus.x_kill_i && (r_state == FIX || (r_state == PREP && w_early));

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            IDLE:    w_state_n = w_start ? PREP : IDLE;
            PREP:    w_state_n = w_early ? DONE : ITER;
            ITER:    w_state_n = r_cnt == CW'(N - 1) ? FIX : ITER;
            FIX:     w_state_n = DONE;
            DONE:    w_state_n = bus.x_stall_i ? DONE : IDLE;
            default: w_state_n = IDLE;
        endcase
        if (bus.x_kill_i) w_state_n = IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_fun   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_rd    <= '0;
        end else begin
            r_state <= w_state_n;
            if (w_start) begin
                r_rs1 <= bus.d_rs1_i;
                r_rs2 <= bus.d_rs2_i;
                r_fun <= bus.d_fun_i;
            end
            if (r_state == PREP) begin
                r_quo <= w_abs1;
                r_dvs <= w_abs2;
                r_rem <= '0;
                r_cnt <= '0;
            end
            if (r_state == ITER) begin
                r_quo <= w_quo;
                r_rem <= w_rem;
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_load) r_rd <= w_res;
        end
    end
endmodule

// File: tb/tb_urv_seq_divider.sv
// tb_urv_seq_divider: scoreboard bench for the sequential divider (32b radix-2 and 16b radix-4).
module tb_urv_seq_divider;
    logic clk = 0, rst = 1, rst16 = 1, hold = 0;
    int n_chk = 0, n_err = 0, cnt, n;
    logic [31:0] q_exp[$];
    logic [31:0] e, last_rd = 0;

    always #5 clk = ~clk;

    urv_seq_divider_if #(.WIDTH(32)) dif ();
    urv_seq_divider_if #(.WIDTH(16)) dif16 ();

    urv_seq_divider #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dut (.clk_i(clk), .rst_i(rst), .bus(dif));
    urv_seq_divider #(.WIDTH(16), .BITS_PER_CYCLE(2)) u_dut16 (.clk_i(clk), .rst_i(rst16), .bus(dif16));

    assign dif.x_stall_i   = dif.x_stall_req_o | hold;
    assign dif16.x_stall_i = dif16.x_stall_req_o;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic sg;
        sg = !f[0];
        if (b == 0) return f[1] ? a : 32'hFFFF_FFFF;
        if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'h0 : 32'h8000_0000;
        if (sg) return f[1] ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
        return f[1] ? a % b : a / b;
    endfunction

    function automatic int exp_stall(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef URV_DIV_EARLY_OUT_EN
        logic sg;
        longint ma, mb;
        sg = !f[0];
        ma = (sg && a[31]) ? longint'(~a) + 1 : longint'(a);
        mb = (sg && b[31]) ? longint'(~b) + 1 : longint'(b);
        if (b == 0 || (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) || ma < mb) return 2;
`endif
        return 35;
    endfunction

    task automatic do_div(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input int hold_n);
        @(negedge clk);
        hold = hold_n > 0;
        dif.d_fun_i = f; dif.d_rs1_i = a; dif.d_rs2_i = b;
        dif.d_valid_i = 1; dif.d_is_divide_i = 1;
        q_exp.push_back(model(f, a, b));
        #1 cnt = dif.x_stall_req_o ? 1 : 0;
        @(posedge clk);
        #1 dif.d_valid_i = 0; dif.d_is_divide_i = 0; dif.d_rs1_i = $urandom; dif.d_rs2_i = $urandom;
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (!dif.x_stall_req_o) break;
            cnt++; n++;
        end
        if (n >= 200) chk("timeout", n, 0);
        e = q_exp.pop_front();
        chk("rd", dif.x_rd_o, e);
        chk("stall_len", cnt, exp_stall(f, a, b));
        last_rd = e;
        for (int k = 0; k < hold_n; k++) begin
            @(negedge clk);
            chk("hold_rd", dif.x_rd_o, e);
            chk("hold_req", {31'b0, dif.x_stall_req_o}, 0);
        end
        hold = 0;
    endtask

    task automatic start16(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        dif16.d_fun_i = 3'b101; dif16.d_rs1_i = a; dif16.d_rs2_i = b;
        dif16.d_valid_i = 1; dif16.d_is_divide_i = 1;
        #1 cnt = dif16.x_stall_req_o ? 1 : 0;
        @(posedge clk);
        #1 dif16.d_valid_i = 0; dif16.d_is_divide_i = 0;
    endtask

    initial begin
        dif.x_kill_i = 0; dif.d_valid_i = 0; dif.d_is_divide_i = 0;
        dif.d_fun_i = 0; dif.d_rs1_i = 0; dif.d_rs2_i = 0;
        dif16.x_kill_i = 0; dif16.d_valid_i = 0; dif16.d_is_divide_i = 0;
        dif16.d_fun_i = 0; dif16.d_rs1_i = 0; dif16.d_rs2_i = 0;
        #1;
        chk("rst_rd", dif.x_rd_o, 0);
        chk("rst_req", {31'b0, dif.x_stall_req_o}, 0);
        repeat (2) @(negedge clk);
        rst = 0; rst16 = 0;

        do_div(3'b101, 100, 7, 0);
        do_div(3'b111, 100, 7, 0);
        do_div(3'b100, -32'sd7, 2, 0);
        do_div(3'b110, -32'sd7, 2, 0);
        do_div(3'b100, 7, -32'sd2, 0);
        do_div(3'b110, 7, -32'sd2, 0);
        do_div(3'b100, 5, 0, 0);
        do_div(3'b111, 5, 0, 0);
        do_div(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_div(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_div(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 0);

        // kill at ITER cycle 10
        @(negedge clk);
        dif.d_fun_i = 3'b101; dif.d_rs1_i = 1000; dif.d_rs2_i = 3;
        dif.d_valid_i = 1; dif.d_is_divide_i = 1;
        @(posedge clk);
        #1 dif.d_valid_i = 0; dif.d_is_divide_i = 0;
        repeat (11) @(negedge clk);
        chk("pre_kill_req", {31'b0, dif.x_stall_req_o}, 1);
        dif.x_kill_i = 1;
        #1 chk("kill_req", {31'b0, dif.x_stall_req_o}, 0);
        @(posedge clk);
        #1 dif.x_kill_i = 0;
        @(negedge clk);
        chk("kill_idle", {31'b0, dif.x_stall_req_o}, 0);
        chk("kill_rd", dif.x_rd_o, last_rd);
        do_div(3'b101, 9, 3, 0);

        // kill together with start
        @(negedge clk);
        dif.d_valid_i = 1; dif.d_is_divide_i = 1; dif.x_kill_i = 1;
        #1 chk("kill_start_req", {31'b0, dif.x_stall_req_o}, 0);
        @(posedge clk);
        #1 dif.d_valid_i = 0; dif.d_is_divide_i = 0; dif.x_kill_i = 0;
        @(negedge clk);
        chk("kill_start_idle", {31'b0, dif.x_stall_req_o}, 0);

        do_div(3'b101, 1234567, 89, 4);
        do_div(3'b101, 32'hFFFF_FFFF, 32'h0001_0000, 0);

        for (int i = 0; i < 16; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : ($urandom >> $urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1) b = -b;
            do_div({1'b1, 2'($urandom_range(0, 3))}, a, b, 0);
        end

        // 16-bit, 2 bits per cycle
        start16(16'hFFFF, 3);
        q_exp.push_back(32'h5555);
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (!dif16.x_stall_req_o) break;
            cnt++; n++;
        end
        if (n >= 100) chk("timeout16", n, 0);
        e = q_exp.pop_front();
        chk("rd16", {16'b0, dif16.x_rd_o}, e);
        chk("stall_len16", cnt, 11);

        start16(16'hFFFF, 3);
        repeat (4) @(negedge clk);
        rst16 = 1;
        #1 chk("rst16_rd", {16'b0, dif16.x_rd_o}, 0);
        chk("rst16_req", {31'b0, dif16.x_stall_req_o}, 0);
        @(negedge clk);
        rst16 = 0;
        @(negedge clk);
        chk("rst16_idle", {31'b0, dif16.x_stall_req_o}, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
